// File: rtl/dvi_frame_sched.sv
// Raster timing generator and frame-boundary source arbiter feeding a DVI/HDMI TMDS transmitter.
// Optional ext-source underrun substitution/flag: define DVI_FRAME_SCHED_UNDERRUN_EN.
module dvi_frame_sched #(
    parameter int          H_ACTIVE = 1920,
    parameter int          H_FP     = 88,
    parameter int          H_SYNC   = 44,
    parameter int          H_BP     = 148,
    parameter int          V_ACTIVE = 1080,
    parameter int          V_FP     = 4,
    parameter int          V_SYNC   = 5,
    parameter int          V_BP     = 36,
    parameter logic        HS_POL   = 1'b1,
    parameter logic        VS_POL   = 1'b1,
    parameter logic [23:0] FILL_RGB = 24'h000000
) (
    input  logic        pixel_clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        src_sel,
    output logic        src_sel_active,
    output logic        running,
    output logic        pat_req,
    input  logic [23:0] pat_data,
    output logic        ext_req,
    input  logic [23:0] ext_data,
    input  logic        ext_valid,
    output logic        video_hsync,
    output logic        video_vsync,
    output logic        video_den,
    output logic [23:0] video_data,
    output logic        frame_start,
    output logic        underrun
);

    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] V_ACT_LAST = 12'(V_ACTIVE - 1);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOPPING} state_t;

    state_t      state_reg;
    logic [11:0] h_cnt_reg;
    logic [11:0] v_cnt_reg;
    logic        src_sel_active_reg;
    logic        video_hsync_reg;
    logic        video_vsync_reg;
    logic        video_den_reg;
    logic [23:0] video_data_reg;
    logic        frame_start_reg;
    logic        underrun_reg;

    logic        run_int;
    logic        de_int;
    logic        hs_int;
    logic        vs_int;
    logic        line_end;
    logic        frame_end;
    logic        sel_point;
    logic        starved;
    logic [23:0] pixel_next;

    // Timing is qualified by run state so the held-at-zero counters in IDLE decode as blanking.
    assign run_int   = (state_reg != ST_IDLE);
    assign de_int    = run_int && (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
    assign hs_int    = run_int && (h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END);
    assign vs_int    = run_int && (v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END);
    assign line_end  = (h_cnt_reg == H_LAST);
    assign frame_end = line_end && (v_cnt_reg == V_LAST);
    assign sel_point = line_end && (v_cnt_reg == V_ACT_LAST);

    assign pat_req = de_int && !src_sel_active_reg;
    assign ext_req = de_int && src_sel_active_reg;

`ifdef DVI_FRAME_SCHED_UNDERRUN_EN
    assign starved = ext_req && !ext_valid;
`else
    logic unused_inputs;
    assign starved       = 1'b0;
    assign unused_inputs = ^{ext_valid, FILL_RGB};
`endif

    always_comb begin
        pixel_next = 24'h000000;
        if (starved)
            pixel_next = FILL_RGB;
        else if (de_int)
            pixel_next = src_sel_active_reg ? ext_data : pat_data;
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state_reg          <= ST_IDLE;
            h_cnt_reg          <= 12'd0;
            v_cnt_reg          <= 12'd0;
            src_sel_active_reg <= 1'b0;
            video_hsync_reg    <= ~HS_POL;
            video_vsync_reg    <= ~VS_POL;
            video_den_reg      <= 1'b0;
            video_data_reg     <= 24'h000000;
            frame_start_reg    <= 1'b0;
            underrun_reg       <= 1'b0;
        end else begin
            video_den_reg   <= de_int;
            video_hsync_reg <= hs_int ? HS_POL : ~HS_POL;
            video_vsync_reg <= vs_int ? VS_POL : ~VS_POL;
            video_data_reg  <= pixel_next;
            frame_start_reg <= run_int && (h_cnt_reg == 12'd0) && (v_cnt_reg == 12'd0);
            underrun_reg    <= underrun_reg | starved;

            case (state_reg)
                ST_IDLE: begin
                    h_cnt_reg          <= 12'd0;
                    v_cnt_reg          <= 12'd0;
                    src_sel_active_reg <= src_sel;
                    if (enable)
                        state_reg <= ST_RUN;
                end
                default: begin
                    if (line_end) begin
                        h_cnt_reg <= 12'd0;
                        v_cnt_reg <= (v_cnt_reg == V_LAST) ? 12'd0 : v_cnt_reg + 12'd1;
                    end else begin
                        h_cnt_reg <= h_cnt_reg + 12'd1;
                    end
                    // Source changes only take effect after the last active line.
                    if (sel_point)
                        src_sel_active_reg <= src_sel;
                    if (state_reg == ST_RUN) begin
                        if (!enable)
                            state_reg <= ST_STOPPING;
                    end else if (enable) begin
                        state_reg <= ST_RUN;
                    end else if (frame_end) begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign src_sel_active = src_sel_active_reg;
    assign running        = run_int;
    assign video_hsync    = video_hsync_reg;
    assign video_vsync    = video_vsync_reg;
    assign video_den      = video_den_reg;
    assign video_data     = video_data_reg;
    assign frame_start    = frame_start_reg;
    assign underrun       = underrun_reg;

endmodule

// File: tb/tb_dvi_frame_sched.sv
// Self-checking bench for dvi_frame_sched on a 14x7 raster, against a frame-position reference model.
module tb_dvi_frame_sched;

    localparam int HT = 14;
    localparam int VT = 7;
    localparam int FT = HT * VT;
    localparam logic [23:0] FILL = 24'hFF00FF;
`ifdef DVI_FRAME_SCHED_UNDERRUN_EN
    localparam bit UR_ON = 1'b1;
`else
    localparam bit UR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, src_sel, ext_valid;
    logic [23:0] pat_data, ext_data;
    logic        src_sel_active, running, pat_req, ext_req;
    logic        video_hsync, video_vsync, video_den, frame_start, underrun;
    logic [23:0] video_data;
    logic        n_src_sel_active, n_running, n_pat_req, n_ext_req;
    logic        n_hsync, n_vsync, n_den, n_frame_start, n_underrun;
    logic [23:0] n_data;

    dvi_frame_sched #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .FILL_RGB(FILL)
    ) dut (
        .pixel_clock(clk), .reset(reset), .enable(enable), .src_sel(src_sel),
        .src_sel_active(src_sel_active), .running(running), .pat_req(pat_req),
        .pat_data(pat_data), .ext_req(ext_req), .ext_data(ext_data), .ext_valid(ext_valid),
        .video_hsync(video_hsync), .video_vsync(video_vsync), .video_den(video_den),
        .video_data(video_data), .frame_start(frame_start), .underrun(underrun)
    );

    dvi_frame_sched #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .FILL_RGB(FILL)
    ) dut_n (
        .pixel_clock(clk), .reset(reset), .enable(enable), .src_sel(src_sel),
        .src_sel_active(n_src_sel_active), .running(n_running), .pat_req(n_pat_req),
        .pat_data(pat_data), .ext_req(n_ext_req), .ext_data(ext_data), .ext_valid(ext_valid),
        .video_hsync(n_hsync), .video_vsync(n_vsync), .video_den(n_den),
        .video_data(n_data), .frame_start(n_frame_start), .underrun(n_underrun)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: mode 0 idle, 1 run, 2 stopping; m_pos is the pixel index within the frame.
    int          m_mode = 0;
    int          m_pos = 0;
    bit          m_src = 1'b0;
    bit          m_urun = 1'b0;
    bit          e_den = 1'b0, e_hs = 1'b0, e_vs = 1'b0, e_fs = 1'b0;
    logic [23:0] e_data = 24'h0;

    task automatic tick();
        int h;
        int v;
        bit run;
        bit act;
        h   = m_pos % HT;
        v   = m_pos / HT;
        run = (m_mode != 0);
        act = run && (h < 8) && (v < 4);
        if (reset) begin
            {e_den, e_hs, e_vs, e_fs} = 4'b0000;
            e_data = 24'h0;
            m_urun = 1'b0;
            m_mode = 0;
            m_pos  = 0;
            m_src  = 1'b0;
        end else begin
            e_den  = act;
            e_hs   = run && (h == 10 || h == 11);
            e_vs   = run && (v == 5);
            e_fs   = run && (m_pos == 0);
            e_data = act ? (m_src ? ext_data : pat_data) : 24'h0;
            if (UR_ON && act && m_src && !ext_valid) begin
                e_data = FILL;
                m_urun = 1'b1;
            end
            if (m_mode == 0) begin
                m_src = src_sel;
                if (enable) m_mode = 1;
            end else begin
                if (m_pos == 3 * HT + HT - 1) m_src = src_sel;
                if (m_mode == 1 && !enable) m_mode = 2;
                else if (m_mode == 2 && enable) m_mode = 1;
                else if (m_mode == 2 && m_pos == FT - 1) m_mode = 0;
                m_pos = (m_mode == 0) ? 0 : (m_pos + 1) % FT;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        pat_data = $urandom;
        ext_data = $urandom;
    endtask

    function automatic logic [32:0] exp_vec();
        bit run;
        bit act;
        run = (m_mode != 0);
        act = run && ((m_pos % HT) < 8) && ((m_pos / HT) < 4);
        return {run, m_src, act && !m_src, act && m_src, e_den, e_hs, e_vs, e_fs, m_urun, e_data};
    endfunction

    function automatic logic [32:0] obs_vec();
        return {running, src_sel_active, pat_req, ext_req, video_den, video_hsync,
                video_vsync, frame_start, underrun, video_data};
    endfunction

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; src_sel = 1'($urandom); ext_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_state cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            checks++;
            if ({n_hsync, n_vsync} !== 2'b11) begin
                errors++;
                $display("FAIL reset_inv_sync cyc=%0d got=%b exp=11", cyc, {n_hsync, n_vsync});
            end
            checks++;
        end
        reset = 1'b0;
    endtask

    task automatic test_start();
        int first_den = -1;
        int last_fs = -1;
        src_sel = 1'b0; enable = 1'b1;
        for (int k = 1; k <= 220; k++) begin
            tick();
            if (video_den && first_den < 0) first_den = k;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL start cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            checks++;
            if (frame_start) begin
                if (last_fs >= 0) begin
                    if (cyc - last_fs != FT) begin
                        errors++;
                        $display("FAIL start_fs_period got=%0d exp=%0d", cyc - last_fs, FT);
                    end
                    checks++;
                end
                last_fs = cyc;
            end
        end
        if (first_den != 2) begin
            errors++;
            $display("FAIL start_den_latency got=%0d exp=2", first_den);
        end
        checks++;
    endtask

    task automatic test_switch();
        bit seen = 1'b0;
        for (int n = 0; n < 2 * FT && m_pos != 16; n++) tick();
        src_sel = 1'b1;
        for (int k = 0; k < 2 * FT; k++) begin
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL switch cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            checks++;
            if (src_sel_active && !seen) begin
                seen = 1'b1;
                if (m_pos != 56) begin
                    errors++;
                    $display("FAIL switch_point got_pos=%0d exp_pos=56", m_pos);
                end
                checks++;
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL switch_timeout got=0 exp=1");
        end
        checks++;
    endtask

    task automatic test_stop();
        int fall_k = -1;
        for (int n = 0; n < 2 * FT && m_pos != 28; n++) tick();
        enable = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (!running && fall_k < 0) fall_k = k;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stop cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            checks++;
        end
        if (fall_k != 70) begin
            errors++;
            $display("FAIL stop_running_fall got=%0d exp=70", fall_k);
        end
        checks++;
        if ({running, video_den, video_hsync, video_vsync, pat_req, ext_req} !== 6'b0) begin
            errors++;
            $display("FAIL stop_idle got=%b exp=000000",
                     {running, video_den, video_hsync, video_vsync, pat_req, ext_req});
        end
        checks++;
    endtask

    task automatic test_resume();
        int last_fs = -1;
        enable = 1'b1;
        for (int n = 0; n < 2 * FT && m_pos != 40; n++) tick();
        enable = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        enable = 1'b1;
        for (int k = 0; k < 3 * FT; k++) begin
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL resume cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            checks++;
            if (frame_start) begin
                if (last_fs >= 0) begin
                    if (cyc - last_fs != FT) begin
                        errors++;
                        $display("FAIL resume_fs_period got=%0d exp=%0d", cyc - last_fs, FT);
                    end
                    checks++;
                end
                last_fs = cyc;
            end
        end
    endtask

    task automatic test_polarity();
        int low_hs = 0;
        reset = 1'b1; enable = 1'b0;
        tick(); tick();
        reset = 1'b0;
        if ({n_hsync, n_vsync} !== 2'b11) begin
            errors++;
            $display("FAIL polarity_idle got=%b exp=11", {n_hsync, n_vsync});
        end
        checks++;
        enable = 1'b1;
        tick();
        for (int k = 0; k < FT; k++) begin
            tick();
            if (!n_hsync) low_hs++;
            if ({n_hsync, n_vsync} !== {~e_hs, ~e_vs}) begin
                errors++;
                $display("FAIL polarity cyc=%0d got=%b exp=%b", cyc, {n_hsync, n_vsync}, {~e_hs, ~e_vs});
            end
            checks++;
        end
        if (low_hs != 2 * VT) begin
            errors++;
            $display("FAIL polarity_hs_count got=%0d exp=%0d", low_hs, 2 * VT);
        end
        checks++;
    endtask

    task automatic test_underrun();
        reset = 1'b1; enable = 1'b0; src_sel = 1'b1; ext_valid = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        enable = 1'b1;
        for (int k = 0; k < 2 * FT; k++) begin
            ext_valid = !(m_mode != 0 && (m_pos == 16 || m_pos == 17 || m_pos == 30));
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL underrun cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            checks++;
        end
        ext_valid = 1'b1;
        if (underrun !== UR_ON) begin
            errors++;
            $display("FAIL underrun_sticky got=%b exp=%b", underrun, UR_ON);
        end
        checks++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_clear got=%b exp=0", underrun);
        end
        checks++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            reset     = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            if ($urandom_range(0, 29) == 0) src_sel = ~src_sel;
            ext_valid = ($urandom_range(0, 9) != 0);
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            checks++;
            if ({n_hsync, n_vsync} !== {~e_hs, ~e_vs}) begin
                errors++;
                $display("FAIL random_inv_sync cyc=%0d got=%b exp=%b", cyc, {n_hsync, n_vsync}, {~e_hs, ~e_vs});
            end
            checks++;
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; src_sel = 1'b0; ext_valid = 1'b1;
        pat_data = $urandom; ext_data = $urandom;
        test_reset();
        test_start();
        test_switch();
        test_stop();
        test_resume();
        test_polarity();
        test_underrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
